// File: rtl/decimal_display_driver.sv
// Sequential binary-to-decimal seven-segment driver: double-dabble one bit per clock,
// with signed mode, leading-zero blanking, overflow dashes and a load/ready/done handshake.
module decimal_display_driver #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DIGITS         = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      value,
  input  logic                  signed_in,
  input  logic                  load,
  output logic                  ready,
  output logic                  done,
  output logic                  overflow,
  output logic [DIGITS*8-1:0]   hex
);

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam int unsigned    BcdW    = 4 * DIGITS;
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH - 1);
  localparam logic [7:0]     SegBlank = 8'hFF;
  localparam logic [7:0]     SegDash  = 8'hBF;

  typedef enum logic [1:0] {StIdle, StConvert, StUpdate} state_e;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = SegBlank;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] polarity(input logic [7:0] c);
    return SEG_ACTIVE_LOW ? c : ~c;
  endfunction

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic [BcdW-1:0]      bcd_q, bcd_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 sticky_q, sticky_d;
  logic [DIGITS*8-1:0]  hex_q, hex_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic [BcdW-1:0]      bcd_adj;
  logic [DIGITS*8-1:0]  hex_new;
  logic                 ovf_new;
  logic                 lead;
  logic [3:0]           nib;
  logic [7:0]           code;

  // Add-3 correction applied before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = 4'(bcd_q[4*k +: 4] + 4'd3);
    end
  end

  // Display image of the finished conversion; walks from the top digit so that
  // `lead` stays set only while every digit seen so far is zero.
  always_comb begin
    ovf_new = sticky_q | (neg_q & (bcd_q[BcdW-1 -: 4] != 4'd0));
    hex_new = '0;
    lead    = 1'b1;
    nib     = '0;
    code    = SegBlank;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      nib  = bcd_q[4*k +: 4];
      lead = lead & (nib == 4'd0);
      if (ovf_new) begin
        code = SegDash;
      end else if (neg_q && (k == int'(DIGITS) - 1)) begin
        code = SegDash;
      end else if (BLANK_LEADING && lead && (k != 0)) begin
        code = SegBlank;
      end else begin
        code = seg_digit(nib);
      end
      hex_new[8*k +: 8] = polarity(code);
    end
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    sticky_d = sticky_q;
    hex_d    = hex_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (load) begin
          neg_d    = signed_in & value[WIDTH-1];
          mag_d    = (signed_in & value[WIDTH-1]) ? (~value + WIDTH'(1)) : value;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CntInit;
          state_d  = StConvert;
        end
      end
      StConvert: begin
        bcd_d    = {bcd_adj[BcdW-2:0], mag_q[WIDTH-1]};
        mag_d    = {mag_q[WIDTH-2:0], 1'b0};
        sticky_d = sticky_q | bcd_adj[BcdW-1];
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == '0) state_d = StUpdate;
      end
      StUpdate: begin
        hex_d   = hex_new;
        ovf_d   = ovf_new;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      mag_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sticky_q <= 1'b0;
      hex_q    <= {DIGITS{polarity(SegBlank)}};
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      sticky_q <= sticky_d;
      hex_q    <= hex_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign ready    = (state_q == StIdle);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign hex      = hex_q;

endmodule
